commit_wb: RTL and testbench
============================

COMMIT_WB -- requirements
Module: commit_wb

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of pc_plus4 path.
REQ-002 Parameter DATA_WIDTH, default 32, datapath width; legal values 32 or 64 only.
REQ-003 Parameter CNT_WIDTH, default 32, width of retire counter.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 valid_m  in  1  M-stage slot holds a real instruction.
REQ-008 stall_w  in  1  hold W-stage register contents.
REQ-009 flush_w  in  1  kill the instruction entering W.
REQ-010 reg_write_m  in  1  instruction writes rd.
REQ-011 result_src_m  in  2  result select: 00 ALU, 01 load, 10 pc_plus4, 11 imm_ext.
REQ-012 load_funct3_m  in  3  RISC-V load funct3.
REQ-013 byte_off_m  in  log2(DATA_WIDTH/8)  low address bits of load.
REQ-014 alu_result_m, read_data_m, imm_ext_m  in  DATA_WIDTH each  result candidates.
REQ-015 pc_plus4_m  in  ADDRESS_WIDTH  link value.
REQ-016 rd_m  in  5  destination register.
REQ-017 result_w  out  DATA_WIDTH  write-back data.
REQ-018 reg_write_w  out  1  register-file write enable.
REQ-019 rd_w  out  5  register-file write address.
REQ-020 valid_w  out  1  W slot holds a live instruction.
REQ-021 retire_count  out  CNT_WIDTH  retired-instruction count.

Function
REQ-022 Block SHALL hold one M/W pipeline register; all outputs derive from it (latency 1 cycle M -> W, no combinational M-input-to-output path).
REQ-023 Per rising edge, priority: flush_w > stall_w > load; flush_w clears valid and reg_write bits (other fields don't-care), stall_w holds all register bits, else all M inputs captured.
REQ-024 valid_w SHALL equal the registered valid bit.
REQ-025 reg_write_w SHALL be registered reg_write AND valid_w AND (rd_w != 0); writes to x0 never asserted.
REQ-026 result_w SHALL select registered ALU result, extended load, pc_plus4 (zero-extended to DATA_WIDTH, truncated if wider), or imm_ext per registered result_src.
REQ-027 Load extension from registered read_data and byte_off: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for DATA_WIDTH=64 also 011 ld, 110 lwu; signed forms sign-extend, unsigned forms zero-extend to DATA_WIDTH.
REQ-028 Sub-word lane = byte_off for bytes, byte_off with bit0 ignored for halfwords, byte_off with bits[1:0] ignored for words.
REQ-029 Unlisted funct3 codes (and 011/110 when DATA_WIDTH=32) SHALL pass read_data unmodified.
REQ-030 retire_count SHALL increment by 1 on each edge where valid_w=1 and stall_w=0 and flush_w=0, wrapping modulo 2^CNT_WIDTH.
REQ-031 During stall, outputs remain constant; reg_write_w may repeat the same write every cycle.
REQ-032 flush_w and stall_w together: flush wins, no retire counted that edge.

Reset
REQ-033 rst=1 SHALL immediately (without clk) force valid_w=0, reg_write_w=0, rd_w=0, result_w=0, retire_count=0, all pipeline fields 0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override both; first capture occurs on the first rising edge after rst deasserts.

Verification
REQ-035 Reset: rst pulse between edges -> all outputs 0 before next edge; retire_count=0.
REQ-036 Loads: read_data=0x8000F0A5, lb off=0 -> result 0xFFFFFFA5; lbu off=3 -> 0x00000080; lh off=2 -> 0xFFFF8000; lhu off=0 -> 0x0000F0A5; lw -> 0x8000F0A5.
REQ-037 Select/x0: src=10, pc_plus4=0x104 -> result 0x104; reg_write_m=1, rd_m=0 -> reg_write_w=0.
REQ-038 Stall/flush: load instr A, stall_w=1 three cycles with new M inputs -> outputs hold A, retire_count +1 only on release; flush_w=1 with stall_w=1 -> valid_w=0, reg_write_w=0, no count.
REQ-039 Counter wrap: CNT_WIDTH=4, 17 back-to-back valid retires -> retire_count=1.
REQ-040 DATA_WIDTH=64: read_data=0x80000000_00000000, lwu off=4 -> 0x00000000_80000000; ld -> unchanged.

Source files
------------

// File: rtl/commit_wb.sv
// M/W pipeline register and write-back stage: result selection, load extension,
// x0 write suppression and a retired-instruction counter.
module commit_wb #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_m,
  input  logic                               stall_w,
  input  logic                               flush_w,
  input  logic                               reg_write_m,
  input  logic [1:0]                         result_src_m,
  input  logic [2:0]                         load_funct3_m,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    byte_off_m,
  input  logic [DATA_WIDTH-1:0]              alu_result_m,
  input  logic [DATA_WIDTH-1:0]              read_data_m,
  input  logic [DATA_WIDTH-1:0]              imm_ext_m,
  input  logic [ADDRESS_WIDTH-1:0]           pc_plus4_m,
  input  logic [4:0]                         rd_m,
  output logic [DATA_WIDTH-1:0]              result_w,
  output logic                               reg_write_w,
  output logic [4:0]                         rd_w,
  output logic                               valid_w,
  output logic [CNT_WIDTH-1:0]               retire_count
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);

  logic                     valid_q;
  logic                     reg_write_q;
  logic [1:0]               result_src_q;
  logic [2:0]               funct3_q;
  logic [OFF_W-1:0]         byte_off_q;
  logic [DATA_WIDTH-1:0]    alu_result_q;
  logic [DATA_WIDTH-1:0]    read_data_q;
  logic [DATA_WIDTH-1:0]    imm_ext_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
  logic [4:0]               rd_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic [CNT_WIDTH-1:0]     cnt_d;

  logic [OFF_W-1:0]         half_off;
  logic [OFF_W-1:0]         word_off;
  logic [7:0]               b_lane;
  logic [15:0]              h_lane;
  logic [31:0]              w_lane;
  logic [DATA_WIDTH-1:0]    load_ext;

  // Flush only needs to kill the write; the data fields are don't-care then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= '0;
      funct3_q     <= '0;
      byte_off_q   <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      imm_ext_q    <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall_w) begin
      valid_q      <= valid_m;
      reg_write_q  <= reg_write_m;
      result_src_q <= result_src_m;
      funct3_q     <= load_funct3_m;
      byte_off_q   <= byte_off_m;
      alu_result_q <= alu_result_m;
      read_data_q  <= read_data_m;
      imm_ext_q    <= imm_ext_m;
      pc_plus4_q   <= pc_plus4_m;
      rd_q         <= rd_m;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !stall_w && !flush_w) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Halfword/word lanes ignore the low offset bits rather than faulting on misalignment.
  always_comb begin
    half_off = byte_off_q & ~OFF_W'(1);
    word_off = byte_off_q & ~OFF_W'(3);
    b_lane   = 8'(read_data_q >> {byte_off_q, 3'b000});
    h_lane   = 16'(read_data_q >> {half_off, 3'b000});
    w_lane   = 32'(read_data_q >> {word_off, 3'b000});
    load_ext = read_data_q;
    case (funct3_q)
      3'b000: load_ext = DATA_WIDTH'(signed'(b_lane));
      3'b001: load_ext = DATA_WIDTH'(signed'(h_lane));
      3'b010: load_ext = DATA_WIDTH'(signed'(w_lane));
      3'b100: load_ext = DATA_WIDTH'(b_lane);
      3'b101: load_ext = DATA_WIDTH'(h_lane);
      3'b110: if (DATA_WIDTH == 64) load_ext = DATA_WIDTH'(w_lane);
      default: load_ext = read_data_q;
    endcase
  end

  always_comb begin
    result_w = alu_result_q;
    case (result_src_q)
      2'b00: result_w = alu_result_q;
      2'b01: result_w = load_ext;
      2'b10: result_w = DATA_WIDTH'(pc_plus4_q);
      2'b11: result_w = imm_ext_q;
      default: result_w = alu_result_q;
    endcase
  end

  assign valid_w      = valid_q;
  assign reg_write_w  = reg_write_q & valid_q & (rd_q != 5'd0);
  assign rd_w         = rd_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_commit_wb.sv
// Directed bench for commit_wb: a default 32-bit instance plus a 64-bit
// instance with a 4-bit retire counter sharing the same control inputs.
module tb_commit_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, stall_w, flush_w, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  load_funct3_m;
  logic [1:0]  a_off;
  logic [2:0]  b_off;
  logic [31:0] a_alu, a_rdata, a_imm, pc_plus4_m;
  logic [63:0] b_alu, b_rdata, b_imm;
  logic [4:0]  rd_m;

  logic [31:0] a_result, a_cnt;
  logic        a_rw, a_valid;
  logic [4:0]  a_rd;
  logic [63:0] b_result;
  logic [3:0]  b_cnt;
  logic        b_rw, b_valid;
  logic [4:0]  b_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  commit_wb u_a (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_w(stall_w), .flush_w(flush_w),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .load_funct3_m(load_funct3_m),
    .byte_off_m(a_off), .alu_result_m(a_alu), .read_data_m(a_rdata), .imm_ext_m(a_imm),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .result_w(a_result), .reg_write_w(a_rw),
    .rd_w(a_rd), .valid_w(a_valid), .retire_count(a_cnt)
  );

  commit_wb #(.DATA_WIDTH(64), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_w(stall_w), .flush_w(flush_w),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .load_funct3_m(load_funct3_m),
    .byte_off_m(b_off), .alu_result_m(b_alu), .read_data_m(b_rdata), .imm_ext_m(b_imm),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .result_w(b_result), .reg_write_w(b_rw),
    .rd_w(b_rd), .valid_w(b_valid), .retire_count(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    valid_m = v; reg_write_m = rw; result_src_m = src;
    load_funct3_m = f3; a_off = off; rd_m = rd;
  endtask

  initial begin
    rst = 1'b1; valid_m = 0; stall_w = 0; flush_w = 0; reg_write_m = 0;
    result_src_m = 0; load_funct3_m = 0; a_off = 0; b_off = 0; rd_m = 0;
    a_alu = 0; a_rdata = 0; a_imm = 0; pc_plus4_m = 0;
    b_alu = 0; b_rdata = 0; b_imm = 0;
    tick(); tick();
    rst = 1'b0;

    // Load something live, then reset between edges
    a_rdata = 32'h8000F0A5;
    drive(1, 1, 2'b01, 3'b010, 2'd0, 5'd5);
    tick();
    check("pre_rst_result", 64'(a_result), 64'h8000F0A5);
    check("pre_rst_valid", 64'(a_valid), 64'h1);
    check("pre_rst_rw", 64'(a_rw), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(a_valid), 64'h0);
    check("rst_rw", 64'(a_rw), 64'h0);
    check("rst_rd", 64'(a_rd), 64'h0);
    check("rst_result", 64'(a_result), 64'h0);
    check("rst_cnt", 64'(a_cnt), 64'h0);
    check("rst_b_result", b_result, 64'h0);
    #1 rst = 1'b0;

    // Load extension, back-to-back valid instructions
    drive(1, 1, 2'b01, 3'b000, 2'd0, 5'd5); tick();
    check("lb_off0", 64'(a_result), 64'hFFFFFFA5);
    check("cnt_first", 64'(a_cnt), 64'h0);
    drive(1, 1, 2'b01, 3'b100, 2'd3, 5'd5); tick();
    check("lbu_off3", 64'(a_result), 64'h00000080);
    check("cnt_1", 64'(a_cnt), 64'h1);
    drive(1, 1, 2'b01, 3'b001, 2'd2, 5'd5); tick();
    check("lh_off2", 64'(a_result), 64'hFFFF8000);
    drive(1, 1, 2'b01, 3'b101, 2'd0, 5'd5); tick();
    check("lhu_off0", 64'(a_result), 64'h0000F0A5);
    drive(1, 1, 2'b01, 3'b010, 2'd0, 5'd5); tick();
    check("lw", 64'(a_result), 64'h8000F0A5);
    drive(1, 1, 2'b01, 3'b001, 2'd3, 5'd5); tick();
    check("lh_off3_bit0_ignored", 64'(a_result), 64'hFFFF8000);
    drive(1, 1, 2'b01, 3'b000, 2'd1, 5'd5); tick();
    check("lb_off1", 64'(a_result), 64'hFFFFFFF0);
    drive(1, 1, 2'b01, 3'b111, 2'd1, 5'd5); tick();
    check("f3_111_pass", 64'(a_result), 64'h8000F0A5);
    check("cnt_7", 64'(a_cnt), 64'h7);

    // pc_plus4 select and x0 suppression
    pc_plus4_m = 32'h104;
    drive(1, 1, 2'b10, 3'b000, 2'd0, 5'd0); tick();
    check("pc4_result", 64'(a_result), 64'h104);
    check("x0_rw", 64'(a_rw), 64'h0);
    check("x0_valid", 64'(a_valid), 64'h1);

    // Instruction A, then stall with changing M inputs
    a_alu = 32'h12345678;
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd7); tick();
    check("A_result", 64'(a_result), 64'h12345678);
    check("A_rd", 64'(a_rd), 64'd7);
    check("A_cnt", 64'(a_cnt), 64'd9);
    stall_w = 1'b1;
    a_alu = 32'hDEADBEEF; a_imm = 32'h55;
    drive(1, 1, 2'b11, 3'b000, 2'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_result", 64'(a_result), 64'h12345678);
      check("stall_rd", 64'(a_rd), 64'd7);
      check("stall_rw", 64'(a_rw), 64'h1);
      check("stall_cnt", 64'(a_cnt), 64'd9);
    end
    stall_w = 1'b0; tick();
    check("release_result", 64'(a_result), 64'h55);
    check("release_rd", 64'(a_rd), 64'd9);
    check("release_cnt", 64'(a_cnt), 64'd10);

    // Flush together with stall
    stall_w = 1'b1; flush_w = 1'b1; tick();
    check("flush_valid", 64'(a_valid), 64'h0);
    check("flush_rw", 64'(a_rw), 64'h0);
    check("flush_cnt", 64'(a_cnt), 64'd10);
    stall_w = 1'b0; flush_w = 1'b0;
    drive(0, 1, 2'b00, 3'b000, 2'd0, 5'd3); tick();
    check("bubble_valid", 64'(a_valid), 64'h0);
    check("bubble_rw", 64'(a_rw), 64'h0);
    check("bubble_cnt", 64'(a_cnt), 64'd10);

    // 64-bit loads; 32-bit instance passes 110/011 through
    b_rdata = 64'h80000000_00000000; b_off = 3'd4;
    drive(1, 1, 2'b01, 3'b110, 2'd0, 5'd4); tick();
    check("b_lwu_off4", b_result, 64'h00000000_80000000);
    check("a_f3_110_pass", 64'(a_result), 64'h8000F0A5);
    drive(1, 1, 2'b01, 3'b011, 2'd0, 5'd4); tick();
    check("b_ld", b_result, 64'h80000000_00000000);
    check("a_f3_011_pass", 64'(a_result), 64'h8000F0A5);
    drive(1, 1, 2'b01, 3'b010, 2'd0, 5'd4); tick();
    check("b_lw_off4", b_result, 64'hFFFFFFFF_80000000);

    // Counter wrap: 17 retires on a 4-bit counter
    #2 rst = 1'b1; #1 rst = 1'b0;
    check("wrap_rst_cnt", 64'(b_cnt), 64'h0);
    drive(1, 1, 2'b00, 3'b000, 2'd0, 5'd1);
    for (int i = 0; i < 18; i++) tick();
    check("wrap_b_cnt", 64'(b_cnt), 64'h1);
    check("wrap_a_cnt", 64'(a_cnt), 64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
